// File: rtl/iic_share_ctrl_module_if.sv
// Bundle of the requester-side and function-side signals around the IIC share controller.
// Latency: none, wiring only.
// Backpressure: none here; the master modport (controller) paces requesters through Done/Err.
interface iic_share_ctrl_module_if;
  // port 0 requester
  logic [1:0] Req0_Start;
  logic [7:0] Req0_Addr;
  logic [7:0] Req0_WrData;
  logic       Req0_Done;
  logic       Req0_Err;
  logic [7:0] Req0_RdData;
  // port 1 requester
  logic [1:0] Req1_Start;
  logic [7:0] Req1_Addr;
  logic [7:0] Req1_WrData;
  logic       Req1_Done;
  logic       Req1_Err;
  logic [7:0] Req1_RdData;
  // shared IIC function module
  logic [1:0] Start_Sig;
  logic [7:0] Addr_Sig;
  logic [7:0] WrData;
  logic       Done_Sig;
  logic [7:0] RdData;
  // status
  logic       Busy;
  logic       Grant;

  modport master (
    input  Req0_Start, Req0_Addr, Req0_WrData,
    output Req0_Done, Req0_Err, Req0_RdData,
    input  Req1_Start, Req1_Addr, Req1_WrData,
    output Req1_Done, Req1_Err, Req1_RdData,
    output Start_Sig, Addr_Sig, WrData,
    input  Done_Sig, RdData,
    output Busy, Grant
  );

  modport slave (
    output Req0_Start, Req0_Addr, Req0_WrData,
    input  Req0_Done, Req0_Err, Req0_RdData,
    output Req1_Start, Req1_Addr, Req1_WrData,
    input  Req1_Done, Req1_Err, Req1_RdData,
    input  Start_Sig, Addr_Sig, WrData,
    output Done_Sig, RdData,
    input  Busy, Grant
  );
endinterface

// File: rtl/iic_share_ctrl_module.sv
// Round-robin arbiter sharing one IIC function module between two requesters, with busy timeout.
// Latency: Start_Sig one cycle after the grant edge; Done/Err pulse in the cycle after Done_Sig or expiry.
// Backpressure: requesters hold ReqN_Start until their Done/Err; the losing port waits in IDLE.
module iic_share_ctrl_module #(
  parameter int TIMEOUT = 4096
) (
  input logic                      CLK,
  input logic                      RSTn,
  iic_share_ctrl_module_if.master  bus
);
  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [1:0] CMD_NONE = 2'b00;
  localparam logic [1:0] CMD_RD   = 2'b10;
  localparam logic [1:0] CMD_ILL  = 2'b11;

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RELEASE = 2'd2} state_t;

  state_t        state;
  logic [CW-1:0] busy_cnt;
  logic          grant;
  logic          busy;
  logic [1:0]    start_sig;
  logic [7:0]    addr_sig;
  logic [7:0]    wr_data;
  logic          req0_done, req1_done, req0_err, req1_err;
  logic [7:0]    req0_rd_data, req1_rd_data;

  logic req0_vld, req1_vld, req0_ill, req1_ill;
  logic pick_vld, pick;

  // Decode both commands and choose the winner of this IDLE sample
  always_comb begin
    req0_vld = (bus.Req0_Start != CMD_NONE) && (bus.Req0_Start != CMD_ILL);
    req1_vld = (bus.Req1_Start != CMD_NONE) && (bus.Req1_Start != CMD_ILL);
    req0_ill = (bus.Req0_Start == CMD_ILL);
    req1_ill = (bus.Req1_Start == CMD_ILL);
    pick_vld = req0_vld | req1_vld;
    // on contention the port that was not served last wins
    pick     = (req0_vld && req1_vld) ? ~grant : req1_vld;
  end

  // Arbitration FSM; every output is a register so reset clears them immediately
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state        <= IDLE;
      busy         <= 1'b0;
      busy_cnt     <= '0;
      grant        <= 1'b1;
      start_sig    <= CMD_NONE;
      addr_sig     <= 8'h00;
      wr_data      <= 8'h00;
      req0_done    <= 1'b0;
      req1_done    <= 1'b0;
      req0_err     <= 1'b0;
      req1_err     <= 1'b0;
      req0_rd_data <= 8'h00;
      req1_rd_data <= 8'h00;
    end else begin
      req0_done <= 1'b0;
      req1_done <= 1'b0;
      req0_err  <= 1'b0;
      req1_err  <= 1'b0;
      case (state)
        IDLE: begin
          // illegal commands are bounced without disturbing the shared bus
          req0_err <= req0_ill;
          req1_err <= req1_ill;
          if (pick_vld) begin
            grant     <= pick;
            start_sig <= pick ? bus.Req1_Start  : bus.Req0_Start;
            addr_sig  <= pick ? bus.Req1_Addr   : bus.Req0_Addr;
            wr_data   <= pick ? bus.Req1_WrData : bus.Req0_WrData;
            busy_cnt  <= '0;
            busy      <= 1'b1;
            state     <= BUSY;
          end
        end
        BUSY: begin
          // completion wins over a timeout expiring on the same edge
          if (bus.Done_Sig) begin
            start_sig <= CMD_NONE;
            req0_done <= ~grant;
            req1_done <= grant;
            if (start_sig == CMD_RD) begin
              if (grant) req1_rd_data <= bus.RdData;
              else       req0_rd_data <= bus.RdData;
            end
            state <= RELEASE;
          end else if (busy_cnt == CNT_LAST) begin
            start_sig <= CMD_NONE;
            req0_err  <= ~grant;
            req1_err  <= grant;
            state     <= RELEASE;
          end else begin
            busy_cnt <= busy_cnt + 1'b1;
          end
        end
        RELEASE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.Start_Sig   = start_sig;
  assign bus.Addr_Sig    = addr_sig;
  assign bus.WrData      = wr_data;
  assign bus.Busy        = busy;
  assign bus.Grant       = grant;
  assign bus.Req0_Done   = req0_done;
  assign bus.Req1_Done   = req1_done;
  assign bus.Req0_Err    = req0_err;
  assign bus.Req1_Err    = req1_err;
  assign bus.Req0_RdData = req0_rd_data;
  assign bus.Req1_RdData = req1_rd_data;
endmodule

// File: tb/tb_iic_share_ctrl_module.sv
// Directed bench for the IIC share controller: scoreboarded grants, completions and timeouts.
// Latency: expects Start_Sig one cycle after the grant edge, Done/Err one cycle after Done_Sig/expiry.
// Backpressure: requests are held until Done/Err is seen, then dropped.
module tb_iic_share_ctrl_module;
  localparam int TO = 16;

  logic CLK = 1'b0;
  logic RSTn;

  iic_share_ctrl_module_if bus();

  iic_share_ctrl_module #(.TIMEOUT(TO)) dut (
    .CLK  (CLK),
    .RSTn (RSTn),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       port;
    logic [1:0] cmd;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rd;
    int         done_at;   // Start-visible cycle on which Done_Sig is driven; 0 = never
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] rd0_m, rd1_m;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic p, input logic [1:0] cmd, input logic [7:0] a, input logic [7:0] d);
    if (p) begin
      bus.Req1_Start = cmd; bus.Req1_Addr = a; bus.Req1_WrData = d;
    end else begin
      bus.Req0_Start = cmd; bus.Req0_Addr = a; bus.Req0_WrData = d;
    end
  endtask

  task automatic push(input logic p, input logic [1:0] cmd, input logic [7:0] a,
                      input logic [7:0] d, input logic [7:0] rd, input int done_at);
    exp_t e;
    e.port = p; e.cmd = cmd; e.addr = a; e.wdata = d; e.rd = rd; e.done_at = done_at;
    sb.push_back(e);
  endtask

  function automatic logic [31:0] pulses();
    return 32'({bus.Req0_Done, bus.Req1_Done, bus.Req0_Err, bus.Req1_Err});
  endfunction

  // Wait for the next transaction on the shared bus, compare it with the scoreboard head,
  // play the function module's part and check the completion.
  task automatic service(output int l);
    exp_t e;
    int   n;
    bit   seen;
    logic done_ok;
    seen = 0;
    l = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge CLK);
      if (bus.Start_Sig != 2'b00) begin
        seen = 1;
        l = i + 1;
        break;
      end
    end
    check("start_seen", 32'(seen), 32'd1);
    if (!seen) return;
    if (sb.size() == 0) begin
      check("sb_nonempty", 32'(sb.size()), 32'd1);
      return;
    end
    e = sb.pop_front();
    check("start_cmd", 32'(bus.Start_Sig), 32'(e.cmd));
    check("addr_sig", 32'(bus.Addr_Sig), 32'(e.addr));
    check("wrdata", 32'(bus.WrData), 32'(e.wdata));
    check("grant", 32'(bus.Grant), 32'(e.port));
    check("busy_on", 32'(bus.Busy), 32'd1);
    check("no_pulse_at_start", pulses(), 32'd0);
    // requester scribbles its address/data after the grant; latched copy must not move
    drive(e.port, e.cmd, ~e.addr, ~e.wdata);
    n = 1;
    done_ok = (e.done_at > 0);
    if (done_ok) begin
      while (n < e.done_at) begin
        @(negedge CLK);
        n++;
      end
      check("hold_start", 32'(bus.Start_Sig), 32'(e.cmd));
      check("hold_addr", 32'(bus.Addr_Sig), 32'(e.addr));
      check("hold_wrdata", 32'(bus.WrData), 32'(e.wdata));
      bus.Done_Sig = 1'b1;
      bus.RdData   = e.rd;
      @(negedge CLK);
      bus.Done_Sig = 1'b0;
      bus.RdData   = 8'hEE;
      if (e.cmd == 2'b10) begin
        if (e.port) rd1_m = e.rd;
        else        rd0_m = e.rd;
      end
    end else begin
      while (n < 200) begin
        @(negedge CLK);
        if (bus.Start_Sig == 2'b00) break;
        n++;
      end
      check("busy_cycles", 32'(n), 32'(TO));
    end
    check("req0_done", 32'(bus.Req0_Done), 32'(done_ok && !e.port));
    check("req1_done", 32'(bus.Req1_Done), 32'(done_ok && e.port));
    check("req0_err", 32'(bus.Req0_Err), 32'(!done_ok && !e.port));
    check("req1_err", 32'(bus.Req1_Err), 32'(!done_ok && e.port));
    check("start_clr", 32'(bus.Start_Sig), 32'd0);
    check("release_busy", 32'(bus.Busy), 32'd1);
    check("req0_rddata", 32'(bus.Req0_RdData), 32'(rd0_m));
    check("req1_rddata", 32'(bus.Req1_RdData), 32'(rd1_m));
    drive(e.port, 2'b00, 8'h00, 8'h00);
    @(negedge CLK);
    check("idle_busy", 32'(bus.Busy), 32'd0);
    check("pulse_gone", pulses(), 32'd0);
    check("idle_start", 32'(bus.Start_Sig), 32'd0);
  endtask

  initial begin : main
    int lat;
    bit seen;
    RSTn = 1'b0;
    drive(1'b0, 2'b00, 8'h00, 8'h00);
    drive(1'b1, 2'b00, 8'h00, 8'h00);
    bus.Done_Sig = 1'b0;
    bus.RdData   = 8'h00;
    rd0_m = 8'h00;
    rd1_m = 8'h00;

    // reset state
    repeat (2) @(negedge CLK);
    check("rst_start", 32'(bus.Start_Sig), 32'd0);
    check("rst_addr", 32'(bus.Addr_Sig), 32'd0);
    check("rst_wrdata", 32'(bus.WrData), 32'd0);
    check("rst_busy", 32'(bus.Busy), 32'd0);
    check("rst_grant", 32'(bus.Grant), 32'd1);
    check("rst_pulses", pulses(), 32'd0);
    check("rst_rd0", 32'(bus.Req0_RdData), 32'd0);
    check("rst_rd1", 32'(bus.Req1_RdData), 32'd0);
    RSTn = 1'b1;

    // Done_Sig outside BUSY is ignored
    @(negedge CLK);
    bus.Done_Sig = 1'b1;
    @(negedge CLK);
    bus.Done_Sig = 1'b0;
    check("idle_done_ignored", pulses(), 32'd0);
    check("idle_done_busy", 32'(bus.Busy), 32'd0);

    // both ports at once after reset, then alternating 0,1,0,1
    drive(1'b0, 2'b01, 8'hA0, 8'h01);
    drive(1'b1, 2'b01, 8'hB0, 8'h02);
    push(1'b0, 2'b01, 8'hA0, 8'h01, 8'h00, 2);
    push(1'b1, 2'b01, 8'hB0, 8'h02, 8'h00, 3);
    service(lat);
    check("contend_lat", 32'(lat), 32'd1);
    drive(1'b0, 2'b10, 8'hA1, 8'h00);
    push(1'b0, 2'b10, 8'hA1, 8'h00, 8'h3C, 2);
    service(lat);
    drive(1'b1, 2'b10, 8'hB1, 8'h00);
    push(1'b1, 2'b10, 8'hB1, 8'h00, 8'h77, 1);
    service(lat);
    service(lat);

    // port 0 write, Start_Sig one cycle after grant
    drive(1'b0, 2'b01, 8'hAA, 8'hAA);
    push(1'b0, 2'b01, 8'hAA, 8'hAA, 8'h00, 3);
    service(lat);
    check("wr_lat", 32'(lat), 32'd1);

    // port 1 read returning 0x5C; port 0 read data must stay 0x3C
    drive(1'b1, 2'b10, 8'hAA, 8'h00);
    push(1'b1, 2'b10, 8'hAA, 8'h00, 8'h5C, 2);
    service(lat);
    check("rd1_5c", 32'(bus.Req1_RdData), 32'h5C);
    check("rd0_kept", 32'(bus.Req0_RdData), 32'h3C);

    // illegal command on port 0 alongside a port 1 write
    drive(1'b0, 2'b11, 8'h12, 8'h34);
    drive(1'b1, 2'b01, 8'h33, 8'h44);
    push(1'b1, 2'b01, 8'h33, 8'h44, 8'h00, 2);
    @(negedge CLK);
    check("ill_err0", 32'(bus.Req0_Err), 32'd1);
    check("ill_err1", 32'(bus.Req1_Err), 32'd0);
    check("ill_done", 32'({bus.Req0_Done, bus.Req1_Done}), 32'd0);
    check("ill_start", 32'(bus.Start_Sig), 32'd1);
    check("ill_grant", 32'(bus.Grant), 32'd1);
    drive(1'b0, 2'b00, 8'h00, 8'h00);
    service(lat);

    // timeout with Done_Sig held low, then Done on the expiry edge
    drive(1'b1, 2'b01, 8'h10, 8'h20);
    push(1'b1, 2'b01, 8'h10, 8'h20, 8'h00, 0);
    service(lat);
    drive(1'b0, 2'b10, 8'h40, 8'h00);
    push(1'b0, 2'b10, 8'h40, 8'h00, 8'h9D, TO);
    service(lat);

    // reset in the middle of BUSY
    drive(1'b1, 2'b01, 8'h55, 8'h66);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      if (bus.Start_Sig != 2'b00) begin
        seen = 1;
        break;
      end
    end
    check("mid_start_seen", 32'(seen), 32'd1);
    @(negedge CLK);
    RSTn = 1'b0;
    #1;
    check("mid_rst_start", 32'(bus.Start_Sig), 32'd0);
    check("mid_rst_busy", 32'(bus.Busy), 32'd0);
    check("mid_rst_pulses", pulses(), 32'd0);
    check("mid_rst_grant", 32'(bus.Grant), 32'd1);
    check("mid_rst_rd0", 32'(bus.Req0_RdData), 32'd0);
    rd0_m = 8'h00;
    rd1_m = 8'h00;
    drive(1'b1, 2'b00, 8'h00, 8'h00);
    @(negedge CLK);
    check("mid_rst_quiet", pulses(), 32'd0);
    RSTn = 1'b1;
    @(negedge CLK);
    check("post_rst_pulses", pulses(), 32'd0);
    drive(1'b0, 2'b01, 8'hC0, 8'hC1);
    drive(1'b1, 2'b01, 8'hD0, 8'hD1);
    push(1'b0, 2'b01, 8'hC0, 8'hC1, 8'h00, 2);
    push(1'b1, 2'b01, 8'hD0, 8'hD1, 8'h00, 2);
    service(lat);
    service(lat);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
